serial_add_ctrl: RTL
====================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request a new addition; sampled each rising edge.
REQ-005 SHALL have port: a  input  WIDTH  operand A; captured on the start-accept edge.
REQ-006 SHALL have port: b  input  WIDTH  operand B; captured on the start-accept edge.
REQ-007 SHALL have port: cin  input  1  carry-in; captured on the start-accept edge.
REQ-008 SHALL have port: busy  output  1  high while an addition is in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when a result is valid.
REQ-010 SHALL have port: sum  output  WIDTH  result of the last completed addition.
REQ-011 SHALL have port: cout  output  1  carry-out of the last completed addition.

Function
REQ-012 SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, using exactly one 1-bit full-adder stage per clock.
REQ-013 SHALL implement states IDLE, RUN and DONE; reset state is IDLE.
REQ-014 IDLE -> RUN on an edge with start=1: load a, b into internal shift registers, load cin into the carry flop, clear the bit counter.
REQ-015 In RUN, each edge SHALL add bit 0 of both shift registers plus the carry flop, shift the sum bit into an internal result register from the MSB end, shift both operand registers right by one, update the carry flop, and increment the counter.
REQ-016 RUN -> DONE on the edge processing bit WIDTH-1; on that same edge sum and cout SHALL be updated from the internal result register and carry.
REQ-017 done SHALL be high only in DONE, i.e. in the single cycle following edge E0+WIDTH, where E0 is the start-accept edge.
REQ-018 busy SHALL be high exactly in RUN (WIDTH cycles per operation).
REQ-019 DONE -> RUN on an edge with start=1 (back-to-back accept, same actions as REQ-014); otherwise DONE -> IDLE.
REQ-020 start while in RUN SHALL be ignored; the operation in progress and its operands are unaffected.
REQ-021 sum and cout SHALL hold their value from DONE until the next DONE, including while a later operation is in RUN.
REQ-022 Changes to a, b or cin after the accept edge SHALL NOT affect the result.
REQ-023 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap or overflow for any legal WIDTH.

Reset
REQ-024 rst=1 at a rising edge SHALL force state IDLE, busy=0, done=0, sum=0, cout=0, and clear the counter, carry and internal shift registers.
REQ-025 rst SHALL take priority over start on the same edge; reset in RUN SHALL abort without a done pulse.
REQ-026 After rst deasserts, the first edge with start=1 SHALL be accepted normally.

Configuration
REQ-027 With macro SERIAL_ADD_CTRL_OVF_EN defined, the module SHALL add output port ovf (1 bit), the two's-complement overflow of the addition (carry into MSB XOR carry out of MSB), updated with sum, held as sum, reset to 0.
REQ-028 Without SERIAL_ADD_CTRL_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-029 a=0x5A, b=0x33, cin=0, start pulse at E0 -> busy high 8 cycles, done pulse in cycle after E0+8, sum=0x8D, cout=0, ovf=1.
REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0.
REQ-031 start re-asserted with a=0x11, b=0x22 during RUN of 0x5A+0x33 -> ignored; result 0x8D/0, done pulses once, sum stays 0x8D afterwards.
REQ-032 start held high through DONE with new operands 0x10+0x20 -> accepted in DONE with no IDLE cycle; second done 8 cycles later, sum=0x30; sum stays 0x8D throughout the second RUN.
REQ-033 rst asserted after 3 RUN cycles -> next cycle busy=0, done=0, sum=0x00, cout=0, no done pulse; a following start with 0x01+0x02 yields sum=0x03 after 8 cycles.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: {cout,sum} = a + b + cin, one full-adder step per clock, LSB first.
// Define SERIAL_ADD_CTRL_OVF_EN to add the two's-complement overflow output ovf.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_CTRL_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;

  assign fa_s = opa[0] ^ opb[0] ^ carry;
  assign fa_c = (opa[0] & opb[0]) | (carry & (opa[0] ^ opb[0]));

  // The counter stops at WIDTH-1 and is cleared on the last step, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_ADD_CTRL_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
          end
        end
        RUN: begin
          res   <= {fa_s, res[WIDTH-1:1]};
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= fa_c;
          if (cnt == LAST) begin
            sum   <= {fa_s, res[WIDTH-1:1]};
            cout  <= fa_c;
`ifdef SERIAL_ADD_CTRL_OVF_EN
            ovf   <= carry ^ fa_c;
`endif
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt   <= cnt + 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
